bf16_div: RTL and testbench

Iterative bfloat16 divider, the inverse companion of the team's combinational bfloat16 multiplier. Accepts a dividend/divisor pair over a valid/ready handshake, computes the quotient with a one-bit-per-cycle restoring mantissa divider, and returns a packed bfloat16 result with status flags over a second valid/ready handshake. It sits beside the multiplier in the FPU datapath and uses the same truncating, no-subnormal number model.

---
 rtl/bf16_div.sv | 207 ++++++++++++++++++++
 tb/tb_bf16_div.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_div.sv
// bf16_div: iterative bfloat16 divider.
// Restoring mantissa division, one quotient bit per cycle, nine steps.
// Number model matches the companion multiplier: exponent field 0 is zero
// (fraction flushed), exponent 0xFF is an ordinary value, truncation only.
module bf16_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturated magnitude with the quotient sign (used for overflow and x/0).
  function automatic logic [15:0] pack_max(input logic sign);
    pack_max = {sign, 8'hFF, 7'h00};
  endfunction

  // Signed zero.
  function automatic logic [15:0] pack_zero(input logic sign);
    pack_zero = {sign, 15'h0000};
  endfunction

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         m2_q, m2_d;
  logic [9:0]         rem_q, rem_d;
  logic [8:0]         q_q, q_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [15:0]        res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               dbz_q, dbz_d;
  logic               out_valid_q, out_valid_d;

  logic [7:0]         e1_s, e2_s;
  logic [6:0]         f1_s, f2_s;
  logic               accept_s;
  logic               ge_s;
  logic [9:0]         rem_sub_s;
  logic [8:0]         q_step_s;
  logic signed [9:0]  exp_norm_s;
  logic [6:0]         frac_norm_s;

  assign e1_s = op1[14:7];
  assign e2_s = op2[14:7];
  assign f1_s = op1[6:0];
  assign f2_s = op2[6:0];

  // Idle is the only accepting state; held low while reset is asserted.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept_s = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign res         = res_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

  // One restoring-division step plus normalization of the completed quotient.
  always_comb begin
    ge_s      = (rem_q >= {2'b00, m2_q});
    if (ge_s) begin
      rem_sub_s = rem_q - {2'b00, m2_q};
    end else begin
      rem_sub_s = rem_q;
    end
    q_step_s  = {q_q[7:0], ge_s};
    // Quotient lies in [128, 511]: top bit set means no exponent adjust.
    if (q_step_s[8]) begin
      exp_norm_s  = exp_q;
      frac_norm_s = q_step_s[7:1];
    end else begin
      exp_norm_s  = exp_q - 10'sd1;
      frac_norm_s = q_step_s[6:0];
    end
  end

  // Next-state and datapath update for the IDLE/DIV/DONE controller.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    m2_d        = m2_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sign_d = op1[15] ^ op2[15];
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (e2_s == 8'h00) begin
            // Division by zero resolves immediately; 0/0 gives the canonical NaN.
            dbz_d       = 1'b1;
            if (e1_s == 8'h00) begin
              res_d = 16'h7FC0;
            end else begin
              res_d = pack_max(op1[15] ^ op2[15]);
            end
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (e1_s == 8'h00) begin
            res_d       = pack_zero(op1[15] ^ op2[15]);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            m2_d    = {1'b1, f2_s};
            rem_d   = {2'b01, f1_s};
            q_d     = 9'd0;
            cnt_d   = 4'd0;
            exp_d   = $signed({2'b00, e1_s}) - $signed({2'b00, e2_s}) + 10'sd127;
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        rem_d = {rem_sub_s[8:0], 1'b0};
        q_d   = q_step_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          // Ninth step: quotient complete, normalize and range-check.
          if (exp_norm_s > 10'sd254) begin
            res_d = pack_max(sign_q);
            ovf_d = 1'b1;
          end else if (exp_norm_s < 10'sd1) begin
            res_d = pack_zero(sign_q);
            unf_d = 1'b1;
          end else begin
            res_d = {sign_q, exp_norm_s[7:0], frac_norm_s};
          end
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      m2_q        <= 8'd0;
      rem_q       <= 10'd0;
      q_q         <= 9'd0;
      cnt_q       <= 4'd0;
      exp_q       <= 10'sd0;
      res_q       <= 16'h0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      m2_q        <= m2_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bf16_div.sv
// Self-checking bench for bf16_div: directed cases, backpressure, mid-op
// reset and randomized operands against an arithmetic reference model.
module tb_bf16_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  bf16_div dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op1         (op1),
    .op2         (op2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res         (res),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: {div_by_zero, underflow, overflow, res} from the number rules.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    int s, e1, e2, f1, f2, q, e, fr;
    logic [15:0] r;
    s  = a[15] ^ b[15];
    e1 = int'(a[14:7]);
    e2 = int'(b[14:7]);
    f1 = int'(a[6:0]);
    f2 = int'(b[6:0]);
    if (e2 == 0) begin
      r = (e1 == 0) ? 16'h7FC0 : 16'(s * 32768 + 255 * 128);
      return {1'b1, 1'b0, 1'b0, r};
    end
    if (e1 == 0) return {3'b000, 16'(s * 32768)};
    q = ((128 + f1) * 256) / (128 + f2);
    e = e1 - e2 + 127;
    if (q >= 256) begin
      fr = (q / 2) % 128;
    end else begin
      fr = q % 128;
      e  = e - 1;
    end
    if (e > 254) return {3'b001, 16'(s * 32768 + 255 * 128)};
    if (e < 1)   return {3'b010, 16'(s * 32768)};
    return {3'b000, 16'(s * 32768 + e * 128 + fr)};
  endfunction

  function automatic int model_latency(input logic [15:0] a, input logic [15:0] b);
    return (a[14:7] == 8'h00 || b[14:7] == 8'h00) ? 0 : 9;
  endfunction

  // Present operands just after an edge; accepted on the following edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid, bounded.
  task automatic wait_result(input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask

  task automatic check_result(input logic [15:0] a, input logic [15:0] b);
    logic [18:0] m;
    m = model(a, b);
    check("res", 32'(res), 32'(m[15:0]));
    check("flags", {29'd0, div_by_zero, underflow, overflow}, {29'd0, m[18:16]});
  endtask

  task automatic handshake(input int hold);
    logic [15:0] held;
    held = res;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_res", 32'(res), 32'(held));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    start_op(a, b);
    wait_result(model_latency(a, b));
    check_result(a, b);
    handshake(hold);
  endtask

  initial begin
    logic [15:0] a, b, held;
    int          bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op1       = 16'h0000;
    op2       = 16'h0000;

    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_flags", {29'd0, div_by_zero, underflow, overflow}, 32'd0);
    #9 rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed cases, including direct expected constants
    run_op(16'h3F80, 16'h3F80, 0);
    check("one_over_one", 32'(model(16'h3F80, 16'h3F80)), 32'h03F80);
    run_op(16'h40C0, 16'h4000, 1);
    check("six_over_two", 32'(model(16'h40C0, 16'h4000)), 32'h04040);
    run_op(16'h3F80, 16'h4040, 0);
    check("one_over_three", 32'(model(16'h3F80, 16'h4040)), 32'h03EAA);
    run_op(16'hBF80, 16'h0000, 0);
    check("neg_div_zero", 32'(model(16'hBF80, 16'h0000)), 32'h4FF80);
    run_op(16'h0000, 16'h0000, 0);
    run_op(16'h0000, 16'h4000, 0);
    run_op(16'h7F00, 16'h3E80, 0);
    check("overflow_vec", 32'(model(16'h7F00, 16'h3E80)), 32'h17F80);
    run_op(16'h0080, 16'h4000, 0);
    check("underflow_vec", 32'(model(16'h0080, 16'h4000)), 32'h20000);

    // Backpressure: result held, new operands ignored until handshake
    start_op(16'h40C0, 16'h4000);
    wait_result(9);
    check_result(16'h40C0, 16'h4000);
    held     = res;
    op1      = 16'h3F80;
    op2      = 16'h4040;
    in_valid = 1'b1;
    bad      = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("backpressure_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    wait_result(9);
    check_result(16'h3F80, 16'h4040);
    handshake(0);

    // Reset in the middle of a divide
    start_op(16'h40C0, 16'h4000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_res", 32'(res), 32'd0);
    check("midrst_flags", {29'd0, div_by_zero, underflow, overflow}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("midrst_no_result", 32'(bad), 32'd0);
    run_op(16'h40C0, 16'h4000, 0);

    // Randomized operands, occasional zero exponents, random backpressure
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a[14:7] = 8'h00;
      if ($urandom_range(0, 7) == 0) b[14:7] = 8'h00;
      run_op(a, b, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
